// File: rtl/imm_encoder.sv
// Inverse immediate extender: searches for the Instr[23:0] field that reproduces a constant.
// Optional second (inverted-value) pass in mode 00 enabled by defining IMM_ENCODER_INVERT_EN.
module imm_encoder #(
   parameter int ROT_STEPS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_value,
   input  logic [1:0]  in_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_instr,
   output logic        out_ok,
   output logic        out_inv
);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t      state_q;
   logic [31:0] value_q;
   logic [1:0]  mode_q;
   logic [3:0]  rot_q;
   logic        out_valid_q;
   logic [23:0] instr_q;
   logic        ok_q;
`ifdef IMM_ENCODER_INVERT_EN
   logic        pass_q;
   logic        inv_q;
`endif

   logic [31:0] src;
   logic [4:0]  shamt;
   logic [31:0] cand;
   logic        rot_hit;
   logic        last_rot;
   logic [5:0]  sign_diff;
   logic        br_ok;
   logic        done_d;
   logic        restart_d;
   logic [23:0] instr_d;
   logic        ok_d;
   logic        inv_d;

`ifdef IMM_ENCODER_INVERT_EN
   assign src = pass_q ? ~value_q : value_q;
`else
   assign src = value_q;
`endif

   assign shamt    = {rot_q, 1'b0};
   assign cand     = (src << shamt) | (src >> (6'd32 - {1'b0, shamt}));
   assign rot_hit  = (cand[31:8] == 24'h0);
   assign last_rot = (rot_q == 4'(ROT_STEPS - 1));

   // Branch offset must fit a signed 26-bit range: bits 30..25 match the sign bit.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_sext
         assign sign_diff[gi] = value_q[25 + gi] ^ value_q[31];
      end
   endgenerate
   assign br_ok = (sign_diff == 6'h0) && (value_q[1:0] == 2'b00);

   always_comb begin
      done_d    = 1'b1;
      restart_d = 1'b0;
      instr_d   = 24'h0;
      ok_d      = 1'b0;
      inv_d     = 1'b0;
      case (mode_q)
         2'b00: begin
            if (rot_hit) begin
               ok_d    = 1'b1;
               instr_d = {12'h0, rot_q, cand[7:0]};
`ifdef IMM_ENCODER_INVERT_EN
               inv_d   = pass_q;
`endif
            end else if (!last_rot) begin
               done_d = 1'b0;
`ifdef IMM_ENCODER_INVERT_EN
            end else if (!pass_q) begin
               done_d    = 1'b0;
               restart_d = 1'b1;
`endif
            end
         end
         2'b01: begin
            ok_d    = (value_q[31:12] == 20'h0);
            instr_d = ok_d ? {12'h0, value_q[11:0]} : 24'h0;
         end
         2'b10: begin
            ok_d    = br_ok;
            instr_d = br_ok ? value_q[25:2] : 24'h0;
         end
         default: begin
            ok_d    = 1'b0;
            instr_d = 24'h0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         value_q     <= 32'h0;
         mode_q      <= 2'b00;
         rot_q       <= 4'h0;
         out_valid_q <= 1'b0;
         instr_q     <= 24'h0;
         ok_q        <= 1'b0;
`ifdef IMM_ENCODER_INVERT_EN
         pass_q      <= 1'b0;
         inv_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  value_q <= in_value;
                  mode_q  <= in_mode;
                  rot_q   <= 4'h0;
`ifdef IMM_ENCODER_INVERT_EN
                  pass_q  <= 1'b0;
`endif
                  state_q <= SEARCH;
               end
            end
            SEARCH: begin
               if (done_d) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  instr_q     <= instr_d;
                  ok_q        <= ok_d;
`ifdef IMM_ENCODER_INVERT_EN
                  inv_q       <= inv_d;
`endif
               end else if (restart_d) begin
                  rot_q <= 4'h0;
`ifdef IMM_ENCODER_INVERT_EN
                  pass_q <= 1'b1;
`endif
               end else begin
                  rot_q <= rot_q + 4'h1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = out_valid_q;
   assign out_instr = instr_q;
   assign out_ok    = ok_q;
`ifdef IMM_ENCODER_INVERT_EN
   assign out_inv   = inv_q;
`else
   assign out_inv   = 1'b0;
   logic unused_inv;
   assign unused_inv = inv_d;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed table, hold/reset sequences, randomized
// requests against a behavioural model. Honours IMM_ENCODER_INVERT_EN like the design.
module tb_imm_encoder;

   localparam int ROT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_instr;
   logic        out_ok;
   logic        out_inv;

   int n_cmp = 0;
   int n_err = 0;

   imm_encoder #(.ROT_STEPS(ROT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_ok    (out_ok),
      .out_inv   (out_inv)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      logic [1:0]  mode;
      logic [23:0] instr;
      logic        ok;
      logic        inv;
      int          lat;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rol(input logic [31:0] v, input int s);
      if (s == 0) return v;
      return (v << s) | (v >> (32 - s));
   endfunction

   // Reference: search the rotation space arithmetically, smallest rotation first.
   task automatic model(input logic [31:0] v, input logic [1:0] m,
                        output logic [23:0] ei, output logic eo, output logic ev, output int el);
      longint sv;
      ei = 24'h0; eo = 1'b0; ev = 1'b0; el = 1;
      case (m)
         2'd0: begin
            el = ROT;
            for (int r = ROT - 1; r >= 0; r--) begin
               logic [31:0] c;
               c = rol(v, 2 * r);
               if (c < 32'd256) begin
                  ei = 24'(r * 256 + int'(c)); eo = 1'b1; el = r + 1;
               end
            end
`ifdef IMM_ENCODER_INVERT_EN
            if (!eo) begin
               el = 2 * ROT;
               for (int r = ROT - 1; r >= 0; r--) begin
                  logic [31:0] c;
                  c = rol(~v, 2 * r);
                  if (c < 32'd256) begin
                     ei = 24'(r * 256 + int'(c)); eo = 1'b1; ev = 1'b1; el = ROT + r + 1;
                  end
               end
            end
`endif
         end
         2'd1: begin
            if (v < 32'd4096) begin ei = v[23:0]; eo = 1'b1; end
         end
         2'd2: begin
            sv = longint'($signed(v));
            if ((v % 4 == 0) && sv >= -longint'(33554432) && sv <= longint'(33554431)) begin
               ei = 24'((v >> 2) & 32'h00FF_FFFF); eo = 1'b1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic do_req(input logic [31:0] v, input logic [1:0] m, input logic [23:0] ei,
                         input logic eo, input logic ev, input int el, input string nm,
                         input bit hold);
      int lat;
      logic [23:0] held;
      @(negedge clk);
      chk({nm, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_value = v; in_mode = m;
      @(posedge clk); #1;
      in_valid = 1'b0; in_value = $urandom; in_mode = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 3 * ROT) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         n_cmp++; n_err++;
         $display("FAIL %s.timeout: got no out_valid after %0d clocks, expected %0d", nm, lat, el);
         reset = 1'b1; #2; reset = 1'b0;
         return;
      end
      chk({nm, ".latency"}, 32'(lat), 32'(el));
      chk({nm, ".instr"}, 32'(out_instr), 32'(ei));
      chk({nm, ".ok"}, 32'(out_ok), 32'(eo));
      chk({nm, ".inv"}, 32'(out_inv), 32'(ev));
      chk({nm, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      if (hold) begin
         held = out_instr;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, ".hold_instr"}, 32'(out_instr), 32'(held));
            chk({nm, ".hold_in_ready"}, 32'(in_ready), 32'd0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, ".valid_drop"}, 32'(out_valid), 32'd0);
      chk({nm, ".back_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [23:0] ei;
      logic        eo, ev;
      int          el;
      logic [31:0] v;
      logic [1:0]  m;
      logic [7:0]  b;

      tbl[0]  = '{32'h0000_00FF, 2'd0, 24'h0000FF, 1'b1, 1'b0, 1};
      tbl[1]  = '{32'hFF00_0000, 2'd0, 24'h0004FF, 1'b1, 1'b0, 5};
`ifdef IMM_ENCODER_INVERT_EN
      tbl[2]  = '{32'hFFFF_FF00, 2'd0, 24'h0000FF, 1'b1, 1'b1, 17};
      tbl[3]  = '{32'h1234_5678, 2'd0, 24'h000000, 1'b0, 1'b0, 32};
`else
      tbl[2]  = '{32'hFFFF_FF00, 2'd0, 24'h000000, 1'b0, 1'b0, 16};
      tbl[3]  = '{32'h1234_5678, 2'd0, 24'h000000, 1'b0, 1'b0, 16};
`endif
      tbl[4]  = '{32'h0000_03FC, 2'd0, 24'h000FFF, 1'b1, 1'b0, 16};
      tbl[5]  = '{32'h0000_0000, 2'd0, 24'h000000, 1'b1, 1'b0, 1};
      tbl[6]  = '{32'h0000_0ABC, 2'd1, 24'h000ABC, 1'b1, 1'b0, 1};
      tbl[7]  = '{32'h0000_1000, 2'd1, 24'h000000, 1'b0, 1'b0, 1};
      tbl[8]  = '{32'hFFFF_FFF8, 2'd2, 24'hFFFFFE, 1'b1, 1'b0, 1};
      tbl[9]  = '{32'h0000_0006, 2'd2, 24'h000000, 1'b0, 1'b0, 1};
      tbl[10] = '{32'h01FF_FFFC, 2'd2, 24'h7FFFFF, 1'b1, 1'b0, 1};
      tbl[11] = '{32'h0000_0004, 2'd3, 24'h000000, 1'b0, 1'b0, 1};

      reset = 1'b1; in_valid = 1'b0; in_value = 32'h0; in_mode = 2'b00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_instr", 32'(out_instr), 32'd0);
      chk("reset.out_ok", 32'(out_ok), 32'd0);
      chk("reset.out_inv", 32'(out_inv), 32'd0);
      chk("reset.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_req(tbl[i].value, tbl[i].mode, tbl[i].instr, tbl[i].ok, tbl[i].inv, tbl[i].lat,
                $sformatf("tbl%0d", i), 1'b0);
         $display("tbl%0d value=%08h mode=%0d instr=%06h ok=%0b inv=%0b", i, tbl[i].value,
                  tbl[i].mode, out_instr, out_ok, out_inv);
      end

      // Consumer stalls three clocks in DONE.
      do_req(32'h0000_0ABC, 2'd1, 24'h000ABC, 1'b1, 1'b0, 1, "hold", 1'b1);
      $display("hold sequence done");

      // Reset pulse while the search sits at r=7.
      @(negedge clk);
      in_valid = 1'b1; in_value = 32'h1234_5678; in_mode = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      #2;
      chk("midreset.out_valid", 32'(out_valid), 32'd0);
      chk("midreset.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset.idle", 32'(in_ready), 32'd1);
      do_req(32'hFF00_0000, 2'd0, 24'h0004FF, 1'b1, 1'b0, 5, "after_reset", 1'b0);
      $display("reset sequence done");

      for (int i = 0; i < 40; i++) begin
         m = 2'($urandom_range(0, 3));
         b = 8'($urandom);
         case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = rol({24'h0, b}, int'($urandom_range(0, 31)));
            2: v = ~rol({24'h0, b}, int'($urandom_range(0, 31)));
            3: v = $urandom_range(0, 8191);
            default: v = 32'($signed({$urandom_range(0, 32'h03FF_FFFF), 2'b00}) >>> 2) << 0;
         endcase
         model(v, m, ei, eo, ev, el);
         do_req(v, m, ei, eo, ev, el, $sformatf("rand%0d", i), 1'b0);
         $display("rand%0d value=%08h mode=%0d instr=%06h ok=%0b inv=%0b", i, v, m,
                  out_instr, out_ok, out_inv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
